// File: rtl/mult_pkg.sv
// Shared constants, tag type and helpers for the multiplier arbiter slice.
package mult_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Issue register plus one Booth stage per operand bit.
    function automatic int MULT_LAT_OF(input int width);
        return width + 1;
    endfunction

    localparam int NREQ_MAX = 16;
    localparam int ID_W     = 4;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the shared multiplier: request handshake, result strobe, status.
interface mult_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    import mult_pkg::*;

    localparam int CW = clog2(MULT_LAT_OF(WIDTH) + 2);

    logic                    en;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic [NREQ-1:0]         rsp_valid;
    logic [2*WIDTH-1:0]      rsp_data;
    logic [CW-1:0]           inflight;
    logic                    busy;

    modport master (
        output en, req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, inflight, busy
    );

    modport slave (
        input  en, req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, inflight, busy
    );

endinterface

// File: rtl/multiplier.sv
// Radix-2 Booth signed multiplier, one partial-product step per pipeline stage (WIDTH stages).
module multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] c
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0][WIDTH-1:0] a_pipe, b_pipe;
    logic [WIDTH-1:0][PW-1:0]    acc_pipe, acc_d, acc_q;
    logic [WIDTH-2:0][WIDTH-1:0] a_q, b_q;

    // Bit pair {b[i], b[i-1]} selects +a, -a or nothing at weight 2^i.
    function automatic logic [PW-1:0] booth_step(input logic [PW-1:0]    acc,
                                                  input logic [WIDTH-1:0] op_a,
                                                  input logic [WIDTH-1:0] op_b,
                                                  input int               i);
        logic [PW-1:0]  ext;
        logic [WIDTH:0] bx;
        logic [1:0]     pair;
        ext  = {{WIDTH{op_a[WIDTH-1]}}, op_a} << i;
        bx   = {op_b, 1'b0};
        pair = bx[i +: 2];
        case (pair)
            2'b01:   return acc + ext;
            2'b10:   return acc - ext;
            default: return acc;
        endcase
    endfunction

    always_comb begin
        a_pipe[0]   = a;
        b_pipe[0]   = b;
        acc_pipe[0] = '0;
        for (int i = 1; i < WIDTH; i++) begin
            a_pipe[i]   = a_q[i-1];
            b_pipe[i]   = b_q[i-1];
            acc_pipe[i] = acc_q[i-1];
        end
        for (int i = 0; i < WIDTH; i++)
            acc_d[i] = booth_step(acc_pipe[i], a_pipe[i], b_pipe[i], i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_pipe[WIDTH-2:0];
            b_q   <= b_pipe[WIDTH-2:0];
            acc_q <= acc_d;
        end
    end

    assign c = acc_q[WIDTH-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid index at or after ptr.
module rr_arbiter import mult_pkg::*; #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req,
    input  logic                en,
    output logic [N-1:0]        gnt,
    output logic [clog2(N)-1:0] gnt_idx
);
    localparam int IW = clog2(N);

    logic [IW-1:0] ptr_d, ptr_q;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
        // Reset gating keeps ready low for the whole reset window, not just after an edge.
        if (!(en && rst_n)) begin
            gnt     = '0;
            gnt_idx = '0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters; tags each issue and routes results back.
module mult_arbiter import mult_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mult_arbiter_if.slave bus
);
    localparam int MULT_LAT = MULT_LAT_OF(WIDTH);
    localparam int IW       = clog2(NREQ);
    localparam int CW       = clog2(MULT_LAT + 2);

    logic [NREQ-1:0]           gnt;
    logic [IW-1:0]             gnt_idx;
    logic                      hs;
    logic signed [WIDTH-1:0]   mul_a_d, mul_a_q, mul_b_d, mul_b_q;
    logic signed [2*WIDTH-1:0] mul_c;
    tag_t [MULT_LAT-1:0]       tag_d, tag_q;
    logic [NREQ-1:0]           rsp_valid_d, rsp_valid_q;
    logic [2*WIDTH-1:0]        rsp_data_d, rsp_data_q;
    logic [CW-1:0]             inflight_d, inflight_q;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .en      (bus.en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready = gnt;
    assign hs            = |gnt;

    // Without a handshake the register holds; the product it keeps producing carries no valid tag.
    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (hs) begin
            mul_a_d = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            mul_b_d = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        end
    end

    multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (mul_a_q),
        .b     (mul_b_q),
        .c     (mul_c)
    );

    always_comb begin
        tag_d[0].vld = hs;
        tag_d[0].id  = ID_W'(gnt_idx);
        for (int k = 1; k < MULT_LAT; k++) tag_d[k] = tag_q[k-1];
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_q[MULT_LAT-1].vld) begin
            rsp_data_d = mul_c;
            for (int i = 0; i < NREQ; i++)
                rsp_valid_d[i] = (tag_q[MULT_LAT-1].id == ID_W'(i));
        end
    end

    always_comb begin
        inflight_d = inflight_q + CW'(hs) - CW'(|rsp_valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            inflight_q  <= inflight_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.inflight  = inflight_q;
    assign bus.busy      = (inflight_q != '0);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: arbitration order, products, latency, occupancy, en and reset.
module tb_mult_arbiter;
    localparam int W = 8;
    localparam int N = 4;
    localparam int LAT_CYC = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mult_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    mult_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic [N-1:0]   v;
        logic [2*W-1:0] d;
    } rsp_t;

    rsp_t           exp_q[$];
    rsp_t           e;
    logic [2*W-1:0] exp_p [N];
    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    int peak   = 0;

    logic [W-1:0]   rr_a [N] = '{8'd2,     8'hFB,    8'd127,   8'hF9};
    logic [W-1:0]   rr_b [N] = '{8'd3,     8'd4,     8'd127,   8'hF7};
    logic [2*W-1:0] rr_p [N] = '{16'h0006, 16'hFFEC, 16'h3F01, 16'h003F};

    logic [W-1:0]   ex_a [5] = '{8'h80,    8'h7F,    8'h00,    8'hFF,    8'h05};
    logic [W-1:0]   ex_b [5] = '{8'h80,    8'h80,    8'hFF,    8'hFF,    8'h07};
    logic [2*W-1:0] ex_p [5] = '{16'h4000, 16'hC080, 16'h0000, 16'h0001, 16'h0023};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Issues seen at a negedge hand-shake on the next edge; their strobe is due LAT_CYC negedges later.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++)
                if (bus.req_valid[i] && bus.req_ready[i])
                    exp_q.push_back('{cyc + LAT_CYC, N'(1 << i), exp_p[i]});
            if (bus.rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("stray_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_cyc",  32'(cyc),           32'(e.cyc));
                    chk("rsp_vld",  32'(bus.rsp_valid), 32'(e.v));
                    chk("rsp_data", 32'(bus.rsp_data),  32'(e.d));
                end
            end
            if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
        end
    end

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] p);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        exp_p[i]            = p;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic issue1(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] p);
        int t;
        t = 0;
        set_req(i, a, b, p);
        @(negedge clk);
        while (!bus.req_ready[i] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("issue_rdy", 32'(bus.req_ready[i]), 32'd1);
        at_pos();
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((bus.busy || exp_q.size() != 0) && t < 40) begin
            at_pos();
            t++;
        end
        chk("drain_done", 32'(t < 40), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int last_rsp, fall;
        for (int i = 0; i < N; i++) exp_p[i] = '0;
        bus.en        = 1'b1;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;

        #3;
        chk("rst_ready",    32'(bus.req_ready), 32'd0);
        chk("rst_rsp_vld",  32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data),  32'd0);
        chk("rst_inflight", 32'(bus.inflight),  32'd0);
        chk("rst_busy",     32'(bus.busy),      32'd0);
        bus.req_valid = '0;
        at_pos();
        at_pos();
        rst_n = 1'b1;
        at_pos();

        // Round robin: everyone valid, grants rotate 0,1,2,3,0,...
        for (int i = 0; i < N; i++) set_req(i, rr_a[i], rr_b[i], rr_p[i]);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(bus.req_ready), 32'(1 << (k % N)));
        end
        at_pos();
        bus.req_valid = '0;
        drain();

        // Single op from requester 2
        issue1(2, 8'd3, 8'hFE, 16'hFFFA);
        chk("single_inflight", 32'(bus.inflight), 32'd1);
        chk("single_busy",     32'(bus.busy),     32'd1);
        drain();
        chk("single_idle", 32'(bus.inflight), 32'd0);

        // Operand extremes through requester 0
        for (int k = 0; k < 5; k++) issue1(0, ex_a[k], ex_b[k], ex_p[k]);
        drain();

        // Eleven back-to-back issues from requester 1
        peak = 0;
        for (int k = 1; k <= 11; k++) begin
            set_req(1, 8'(k), 8'hFD, 16'(-3 * k));
            @(negedge clk);
            chk("pipe_rdy", 32'(bus.req_ready), 32'b0010);
            at_pos();
        end
        bus.req_valid[1] = 1'b0;
        last_rsp = -1;
        fall     = -1;
        for (int t = 0; t < 40 && fall < 0; t++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) last_rsp = cyc;
            else if (!bus.busy && last_rsp >= 0) fall = cyc;
        end
        chk("busy_fall",     32'(fall - last_rsp), 32'd1);
        chk("peak_inflight", 32'(peak),            32'd10);
        at_pos();

        // en low: grants vanish, issued result still lands, ptr kept
        set_req(3, 8'd6, 8'd7, 16'd42);
        @(negedge clk);
        chk("en_pre", 32'(bus.req_ready), 32'b1000);
        at_pos();
        bus.req_valid[3] = 1'b0;
        bus.en = 1'b0;
        set_req(1, 8'hF0, 8'd2, 16'hFFE0);
        set_req(2, 8'd100, 8'd100, 16'h2710);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("en_low_rdy", 32'(bus.req_ready), 32'd0);
        end
        at_pos();
        bus.en = 1'b1;
        @(negedge clk);
        chk("en_resume", 32'(bus.req_ready), 32'b0010);
        at_pos();
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        chk("en_next", 32'(bus.req_ready), 32'b0100);
        at_pos();
        bus.req_valid[2] = 1'b0;
        drain();

        // Reset with five products in flight
        for (int k = 0; k < 5; k++) begin
            set_req(0, 8'(10 + k), 8'hFD, 16'(-3 * (10 + k)));
            @(negedge clk);
            at_pos();
        end
        bus.req_valid = '0;
        rst_n = 1'b0;
        exp_q.delete();
        set_req(2, 8'd9, 8'hF7, 16'hFFAF);
        #1;
        chk("mid_rst_rsp_vld",  32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", 32'(bus.rsp_data),  32'd0);
        chk("mid_rst_inflight", 32'(bus.inflight),  32'd0);
        chk("mid_rst_busy",     32'(bus.busy),      32'd0);
        chk("mid_rst_ready",    32'(bus.req_ready), 32'd0);
        at_pos();
        at_pos();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 32'(bus.req_ready), 32'b0100);
        at_pos();
        bus.req_valid[2] = 1'b0;
        for (int k = 0; k < 12; k++) at_pos();
        drain();
        chk("exp_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
